// File: rtl/duck_fetch_pkg.sv
// Shared types and default geometry for the duck state fetcher.
package duck_fetch_pkg;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_t;

  localparam int DEF_ADDR_W      = 2;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_NUM_WORDS   = 4;
  localparam int DEF_STATUS_ADDR = 3;

endpackage

// File: rtl/duck_state_fetcher_fetch_shadow_regs.sv
// Staging bank filled word by word during a burst.
// On the commit strobe the whole bank, including the word captured on that
// same edge, is copied into the visible snapshot.
module fetch_shadow_regs #(
  parameter int DATA_W    = 32,
  parameter int NUM_WORDS = 4,
  parameter int IDX_W     = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_cap_en,
  input  logic [IDX_W-1:0]            i_cap_idx,
  input  logic [DATA_W-1:0]           i_cap_data,
  input  logic                        i_commit,
  output logic [NUM_WORDS*DATA_W-1:0] o_snapshot
);

  logic [NUM_WORDS*DATA_W-1:0] r_staging;
  logic [NUM_WORDS*DATA_W-1:0] r_snapshot;
  logic [NUM_WORDS*DATA_W-1:0] w_merged;

  // Staging contents with the word arriving this cycle folded in.
  always_comb begin
    w_merged = r_staging;
    if (i_cap_en) begin
      w_merged[i_cap_idx*DATA_W +: DATA_W] = i_cap_data;
    end
  end

  // Capture incoming words; publish the full bank atomically on commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_staging  <= '0;
      r_snapshot <= '0;
    end else begin
      r_staging <= w_merged;
      if (i_commit) begin
        r_snapshot <= w_merged;
      end
    end
  end

  assign o_snapshot = r_snapshot;

endmodule

// File: rtl/duck_state_fetcher.sv
// Avalon-MM master: per frame, optionally writes back the pending status
// word, then burst-reads the state memory into an atomic snapshot.
// Handshake: memory has no waitrequest and a fixed 1-cycle read latency, so
// a read issued in cycle k returns readdata in cycle k+1 unconditionally;
// frame_start and status_valid are single-cycle pulses with no back-pressure.
module duck_state_fetcher
  import duck_fetch_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int NUM_WORDS   = DEF_NUM_WORDS,
  parameter int STATUS_ADDR = DEF_STATUS_ADDR
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        frame_start,
  input  logic                        status_valid,
  input  logic [DATA_W-1:0]           status_word,
  output logic [ADDR_W-1:0]           mem_address,
  output logic                        mem_chipselect,
  output logic                        mem_write,
  output logic [DATA_W/8-1:0]         mem_byteenable,
  output logic [DATA_W-1:0]           mem_writedata,
  output logic                        mem_clken,
  input  logic [DATA_W-1:0]           mem_readdata,
  output logic [NUM_WORDS*DATA_W-1:0] snapshot,
  output logic                        snapshot_valid,
  output logic                        busy,
  output logic                        frame_overrun,
  output logic [1:0]                  dbg_state
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WORDS - 1);
  localparam logic [ADDR_W-1:0] STS_IDX  = ADDR_W'(STATUS_ADDR);

  fetch_state_t        r_state;
  logic [ADDR_W-1:0]   r_address;
  logic                r_cs;
  logic                r_write;
  logic [DATA_W/8-1:0] r_be;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_pending;
  logic [DATA_W-1:0]   r_pending_word;
  logic                r_cap_en;
  logic [ADDR_W-1:0]   r_cap_idx;
  logic                r_snap_valid;
  logic                r_busy;
  logic                r_overrun;
  logic                w_commit;

  // Sequencer, Avalon drive, pending status register and pulse outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_address      <= '0;
      r_cs           <= 1'b0;
      r_write        <= 1'b0;
      r_be           <= '0;
      r_wdata        <= '0;
      r_pending      <= 1'b0;
      r_pending_word <= '0;
      r_cap_en       <= 1'b0;
      r_cap_idx      <= '0;
      r_snap_valid   <= 1'b0;
      r_busy         <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      r_snap_valid <= 1'b0;
      r_overrun    <= 1'b0;
      r_cap_en     <= 1'b0;
      if (status_valid) begin
        r_pending      <= 1'b1;
        r_pending_word <= status_word;
      end
      if (frame_start && (r_state != ST_IDLE)) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (frame_start) begin
            r_busy <= 1'b1;
            r_cs   <= 1'b1;
            r_be   <= '1;
            if (r_pending) begin
              r_state   <= ST_WRITE;
              r_write   <= 1'b1;
              r_address <= STS_IDX;
              r_wdata   <= r_pending_word;
            end else begin
              r_state   <= ST_READ;
              r_write   <= 1'b0;
              r_address <= '0;
            end
          end
        end
        ST_WRITE: begin
          // A status arriving now stays pending for the next frame.
          if (!status_valid) begin
            r_pending <= 1'b0;
          end
          r_state   <= ST_READ;
          r_write   <= 1'b0;
          r_address <= '0;
        end
        ST_READ: begin
          r_cap_en  <= 1'b1;
          r_cap_idx <= r_address;
          if (r_address == LAST_IDX) begin
            r_state <= ST_DRAIN;
            r_cs    <= 1'b0;
            r_be    <= '0;
          end else begin
            r_address <= r_address + ADDR_W'(1);
          end
        end
        ST_DRAIN: begin
          r_state      <= ST_IDLE;
          r_busy       <= 1'b0;
          r_snap_valid <= 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_commit = (r_state == ST_DRAIN);

  fetch_shadow_regs #(
    .DATA_W    (DATA_W),
    .NUM_WORDS (NUM_WORDS),
    .IDX_W     (ADDR_W)
  ) u_shadow (
    .clk        (clk),
    .rst        (reset),
    .i_cap_en   (r_cap_en),
    .i_cap_idx  (r_cap_idx),
    .i_cap_data (mem_readdata),
    .i_commit   (w_commit),
    .o_snapshot (snapshot)
  );

  assign mem_address    = r_address;
  assign mem_chipselect = r_cs;
  assign mem_write      = r_write;
  assign mem_byteenable = r_be;
  assign mem_writedata  = r_wdata;
  assign mem_clken      = 1'b1;
  assign snapshot_valid = r_snap_valid;
  assign busy           = r_busy;
  assign frame_overrun  = r_overrun;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_duck_state_fetcher.sv
// Directed bench for duck_state_fetcher with a behavioural 4x32 memory.
module tb_duck_state_fetcher;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         frame_start = 1'b0;
  logic         status_valid = 1'b0;
  logic [31:0]  status_word = '0;
  logic [1:0]   mem_address;
  logic         mem_chipselect;
  logic         mem_write;
  logic [3:0]   mem_byteenable;
  logic [31:0]  mem_writedata;
  logic         mem_clken;
  logic [31:0]  mem_readdata;
  logic [127:0] snapshot;
  logic         snapshot_valid;
  logic         busy;
  logic         frame_overrun;
  logic [1:0]   dbg_state;

  logic         preload = 1'b1;
  logic [31:0]  mem [4];
  int           acc_cnt = 0;
  int           wr_cnt = 0;
  int           sv_cnt = 0;
  int           tests_run = 0;
  int           tests_failed = 0;

  // clock / reset
  always #5 clk = ~clk;

  duck_state_fetcher dut (
    .clk            (clk),
    .reset          (reset),
    .frame_start    (frame_start),
    .status_valid   (status_valid),
    .status_word    (status_word),
    .mem_address    (mem_address),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_byteenable (mem_byteenable),
    .mem_writedata  (mem_writedata),
    .mem_clken      (mem_clken),
    .mem_readdata   (mem_readdata),
    .snapshot       (snapshot),
    .snapshot_valid (snapshot_valid),
    .busy           (busy),
    .frame_overrun  (frame_overrun),
    .dbg_state      (dbg_state)
  );

  // memory model: registered address, 1-cycle read, byte writes
  always @(posedge clk) begin
    if (preload) begin
      mem[0] <= 32'h11111111;
      mem[1] <= 32'h22222222;
      mem[2] <= 32'h33333333;
      mem[3] <= 32'h44444444;
      mem_readdata <= '0;
    end else if (mem_clken && mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_byteenable[b]) mem[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
        end
      end else begin
        mem_readdata <= mem[mem_address];
      end
    end
  end

  // bus activity monitor
  always @(posedge clk) begin
    if (mem_chipselect) acc_cnt <= acc_cnt + 1;
    if (mem_chipselect && mem_write) wr_cnt <= wr_cnt + 1;
    if (snapshot_valid) sv_cnt <= sv_cnt + 1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Advance until snapshot_valid (bounded); n = cycles after the start pulse.
  task automatic wait_valid(output int n);
    n = 0;
    do begin
      tick();
      frame_start = 1'b0;
      status_valid = 1'b0;
      n++;
    end while (snapshot_valid !== 1'b1 && n < 20);
  endtask

  task automatic test_reset;
    tests_run++;
    if ({mem_chipselect, mem_write, mem_address, mem_byteenable, mem_writedata} !== 40'h0) begin
      tests_failed++; $display("FAIL reset_mem: got cs=%b wr=%b a=%0d be=%h wd=%h want zeros",
        mem_chipselect, mem_write, mem_address, mem_byteenable, mem_writedata);
    end
    tests_run++;
    if ({mem_clken, snapshot_valid, busy, frame_overrun} !== 4'b1000 || snapshot !== 128'h0) begin
      tests_failed++; $display("FAIL reset_out: got clken=%b sv=%b busy=%b ov=%b snap=%h want 1 0 0 0 0",
        mem_clken, snapshot_valid, busy, frame_overrun, snapshot);
    end
  endtask

  task automatic test_basic_fetch;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (mem_chipselect !== 1'b1 || mem_write !== 1'b0 || mem_address !== 2'(k) ||
          mem_byteenable !== 4'hF || busy !== 1'b1 || snapshot_valid !== 1'b0) begin
        tests_failed++; $display("FAIL basic_read%0d: got cs=%b wr=%b a=%0d be=%h busy=%b sv=%b want 1 0 %0d f 1 0",
          k, mem_chipselect, mem_write, mem_address, mem_byteenable, busy, snapshot_valid, k);
      end
      tick();
    end
    tests_run++;
    if (mem_chipselect !== 1'b0 || busy !== 1'b1 || snapshot_valid !== 1'b0) begin
      tests_failed++; $display("FAIL basic_drain: got cs=%b busy=%b sv=%b want 0 1 0",
        mem_chipselect, busy, snapshot_valid);
    end
    tick();
    tests_run++;
    if (snapshot_valid !== 1'b1 || busy !== 1'b0 ||
        snapshot !== {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}) begin
      tests_failed++; $display("FAIL basic_snap: got sv=%b busy=%b snap=%h want 1 0 44444444333333332222222211111111",
        snapshot_valid, busy, snapshot);
    end
    tick();
    tests_run++;
    if (snapshot_valid !== 1'b0) begin
      tests_failed++; $display("FAIL basic_pulse: got sv=%b want 0", snapshot_valid);
    end
  endtask

  task automatic test_status_write;
    int n;
    int w0;
    status_valid = 1'b1;
    status_word = 32'h000000AB;
    tick();
    status_valid = 1'b0;
    w0 = wr_cnt;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tests_run++;
    if (mem_chipselect !== 1'b1 || mem_write !== 1'b1 || mem_address !== 2'd3 ||
        mem_byteenable !== 4'hF || mem_writedata !== 32'h000000AB) begin
      tests_failed++; $display("FAIL status_wr: got cs=%b wr=%b a=%0d be=%h wd=%h want 1 1 3 f 000000ab",
        mem_chipselect, mem_write, mem_address, mem_byteenable, mem_writedata);
    end
    wait_valid(n);
    tests_run++;
    if (n + 1 !== 7 || snapshot !== {32'h000000AB, 32'h33333333, 32'h22222222, 32'h11111111}) begin
      tests_failed++; $display("FAIL status_snap: got lat=%0d snap=%h want 7 000000ab333333332222222211111111",
        n + 1, snapshot);
    end
    tests_run++;
    if (wr_cnt - w0 !== 1) begin
      tests_failed++; $display("FAIL status_wrcnt: got %0d want 1", wr_cnt - w0);
    end
  endtask

  task automatic test_last_wins;
    int n;
    int w0;
    status_valid = 1'b1; status_word = 32'h5; tick();
    status_valid = 1'b0; tick();
    status_valid = 1'b1; status_word = 32'h9; tick();
    status_valid = 1'b0;
    w0 = wr_cnt;
    frame_start = 1'b1;
    wait_valid(n);
    tick();
    tests_run++;
    if (wr_cnt - w0 !== 1 || mem[3] !== 32'h9 || snapshot[127:96] !== 32'h9) begin
      tests_failed++; $display("FAIL last_wins: got writes=%0d mem3=%h snap3=%h want 1 00000009 00000009",
        wr_cnt - w0, mem[3], snapshot[127:96]);
    end
  endtask

  task automatic test_overrun;
    int a0;
    int s0;
    a0 = acc_cnt;
    s0 = sv_cnt;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick(); tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tests_run++;
    if (frame_overrun !== 1'b1) begin
      tests_failed++; $display("FAIL overrun_pulse: got %b want 1", frame_overrun);
    end
    tick();
    tests_run++;
    if (frame_overrun !== 1'b0 || busy !== 1'b1) begin
      tests_failed++; $display("FAIL overrun_clear: got ov=%b busy=%b want 0 1", frame_overrun, busy);
    end
    tick();
    tests_run++;
    if (snapshot_valid !== 1'b1 || snapshot !== {32'h9, 32'h33333333, 32'h22222222, 32'h11111111}) begin
      tests_failed++; $display("FAIL overrun_snap: got sv=%b snap=%h want 1 00000009333333332222222211111111",
        snapshot_valid, snapshot);
    end
    for (int i = 0; i < 8; i++) tick();
    tests_run++;
    if (acc_cnt - a0 !== 4 || sv_cnt - s0 !== 1) begin
      tests_failed++; $display("FAIL overrun_count: got acc=%0d sv=%0d want 4 1", acc_cnt - a0, sv_cnt - s0);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    int s0;
    int w0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    status_valid = 1'b1; status_word = 32'hEE;
    tick();
    status_valid = 1'b0;
    s0 = sv_cnt;
    reset = 1'b1;
    #1;
    tests_run++;
    if (mem_chipselect !== 1'b0 || mem_write !== 1'b0 || mem_address !== 2'd0 || mem_byteenable !== 4'h0 ||
        busy !== 1'b0 || snapshot_valid !== 1'b0 || snapshot !== 128'h0 || mem_clken !== 1'b1) begin
      tests_failed++; $display("FAIL midreset_out: got cs=%b wr=%b a=%0d be=%h busy=%b sv=%b snap=%h want reset values",
        mem_chipselect, mem_write, mem_address, mem_byteenable, busy, snapshot_valid, snapshot);
    end
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    tests_run++;
    if (sv_cnt - s0 !== 0 || snapshot !== 128'h0) begin
      tests_failed++; $display("FAIL midreset_nosnap: got sv=%0d snap=%h want 0 0", sv_cnt - s0, snapshot);
    end
    w0 = wr_cnt;
    frame_start = 1'b1;
    wait_valid(n);
    tests_run++;
    if (n !== 6 || wr_cnt - w0 !== 0 ||
        snapshot !== {32'h9, 32'h33333333, 32'h22222222, 32'h11111111}) begin
      tests_failed++; $display("FAIL midreset_refetch: got lat=%0d writes=%0d snap=%h want 6 0 00000009333333332222222211111111",
        n, wr_cnt - w0, snapshot);
    end
    tick();
  endtask

  task automatic test_status_coincident;
    int n;
    status_valid = 1'b1; status_word = 32'h66; tick();
    status_valid = 1'b0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tests_run++;
    if (mem_write !== 1'b1 || mem_writedata !== 32'h66) begin
      tests_failed++; $display("FAIL coinc_wr1: got wr=%b wd=%h want 1 00000066", mem_write, mem_writedata);
    end
    status_valid = 1'b1; status_word = 32'h77;
    wait_valid(n);
    tests_run++;
    if (n + 1 !== 7 || snapshot[127:96] !== 32'h66) begin
      tests_failed++; $display("FAIL coinc_snap1: got lat=%0d snap3=%h want 7 00000066", n + 1, snapshot[127:96]);
    end
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tests_run++;
    if (mem_write !== 1'b1 || mem_address !== 2'd3 || mem_writedata !== 32'h77) begin
      tests_failed++; $display("FAIL coinc_wr2: got wr=%b a=%0d wd=%h want 1 3 00000077",
        mem_write, mem_address, mem_writedata);
    end
    wait_valid(n);
    tests_run++;
    if (snapshot !== {32'h77, 32'h33333333, 32'h22222222, 32'h11111111}) begin
      tests_failed++; $display("FAIL coinc_snap2: got snap=%h want 00000077333333332222222211111111", snapshot);
    end
    tick();
  endtask

  task automatic test_back_to_back;
    int n;
    frame_start = 1'b1;
    wait_valid(n);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tests_run++;
    if (mem_chipselect !== 1'b1 || mem_write !== 1'b0 || mem_address !== 2'd0 ||
        busy !== 1'b1 || frame_overrun !== 1'b0) begin
      tests_failed++; $display("FAIL b2b_accept: got cs=%b wr=%b a=%0d busy=%b ov=%b want 1 0 0 1 0",
        mem_chipselect, mem_write, mem_address, busy, frame_overrun);
    end
    wait_valid(n);
    tests_run++;
    if (n + 1 !== 6 || snapshot !== {32'h77, 32'h33333333, 32'h22222222, 32'h11111111}) begin
      tests_failed++; $display("FAIL b2b_snap: got lat=%0d snap=%h want 6 00000077333333332222222211111111",
        n + 1, snapshot);
    end
    tick();
  endtask

  initial begin
    reset = 1'b1;
    preload = 1'b1;
    tick(); tick();
    preload = 1'b0;
    test_reset();
    reset = 1'b0;
    tick();
    test_basic_fetch();
    test_status_write();
    test_last_wins();
    test_overrun();
    test_reset_mid();
    test_status_coincident();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
